// File: rtl/cgra_config_streamer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cgra_config_streamer_if : router write port and fabric output stream link
// Revision 1.0
// ----------------------------------------------------------------------------
interface cgra_config_streamer_if #(
  parameter int ADDR_W = 4,
  parameter int CFG_W  = 6
);
  logic                    cfg_wr_valid;
  logic [ADDR_W-1:0]       cfg_wr_addr;
  logic [CFG_W-1:0]        cfg_wr_data;
  logic                    cfg_wr_ready;
  logic                    out_valid;
  logic                    out_ready;
  logic [ADDR_W+CFG_W-1:0] out_data;
  logic                    out_parity;

  // master: router + fabric chain side; slave: the streamer
  modport master (
    output cfg_wr_valid, cfg_wr_addr, cfg_wr_data, out_ready,
    input  cfg_wr_ready, out_valid, out_data, out_parity
  );
  modport slave (
    input  cfg_wr_valid, cfg_wr_addr, cfg_wr_data, out_ready,
    output cfg_wr_ready, out_valid, out_data, out_parity
  );
endinterface
`default_nettype wire

// File: rtl/cgra_config_streamer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cgra_config_streamer : per-PE routing-word table streamed out as {addr,cfg}
// Revision 1.0
// ----------------------------------------------------------------------------
module cgra_config_streamer #(
  parameter int NUM_PE    = 16,
  parameter int ADDR_W    = 4,
  parameter int CFG_W     = 6,
  parameter bit SKIP_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_clear,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_count,
  cgra_config_streamer_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_PE - 1);
  localparam logic [ADDR_W:0]   MAX_COUNT = (ADDR_W+1)'(NUM_PE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_EMIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                    state;
  state_t                    next_state;
  logic [CFG_W-1:0]          cfg_table [NUM_PE];
  logic [ADDR_W-1:0]         idx;
  logic [CFG_W-1:0]          cur_cfg;
  logic                      skip_entry;
  logic                      last_entry;
  logic                      emit_valid;
  logic [ADDR_W+CFG_W-1:0]   emit_data;
  logic                      emit_parity;

  assign cur_cfg    = cfg_table[idx];
  assign skip_entry = SKIP_ZERO && (cur_cfg == '0);
  assign last_entry = (idx == LAST_IDX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (start) next_state = S_SCAN;
      S_SCAN: begin
        if (!skip_entry)     next_state = S_EMIT;
        else if (last_entry) next_state = S_DONE;
      end
      S_EMIT: begin
        if (bus.out_ready) next_state = last_entry ? S_DONE : S_SCAN;
      end
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Table, scan index and output word; the table only changes while idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_PE; i++) cfg_table[i] <= '0;
      idx         <= '0;
      word_count  <= '0;
      emit_valid  <= 1'b0;
      emit_data   <= '0;
      emit_parity <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cfg_clear) begin
            for (int i = 0; i < NUM_PE; i++) cfg_table[i] <= '0;
          end else if (bus.cfg_wr_valid) begin
            cfg_table[bus.cfg_wr_addr] <= bus.cfg_wr_data;
          end
          if (start) begin
            idx        <= '0;
            word_count <= '0;
          end
        end
        S_SCAN: begin
          if (skip_entry) begin
            if (!last_entry) idx <= idx + 1'b1;
          end else begin
            emit_valid  <= 1'b1;
            emit_data   <= {idx, cur_cfg};
            emit_parity <= ^{idx, cur_cfg};
          end
        end
        S_EMIT: begin
          if (bus.out_ready) begin
            emit_valid <= 1'b0;
            if (word_count != MAX_COUNT) word_count <= word_count + 1'b1;
            if (!last_entry) idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy             = (state != S_IDLE);
  assign done             = (state == S_DONE);
  assign bus.cfg_wr_ready = (state == S_IDLE);
  assign bus.out_valid    = emit_valid;
  assign bus.out_data     = emit_data;
  assign bus.out_parity   = emit_parity;

endmodule
`default_nettype wire

// File: tb/tb_cgra_config_streamer.sv
`default_nettype none
// Bench for cgra_config_streamer: hand-written vector table, directed corner
// sequences and randomized tables checked against a table-level model.
module tb_cgra_config_streamer;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_clear;
  logic       start;
  logic       busy;
  logic       done;
  logic [4:0] word_count;
  logic       start0;
  logic       cfg_clear0;
  logic       busy0;
  logic       done0;
  logic [4:0] word_count0;

  cgra_config_streamer_if #(.ADDR_W(4), .CFG_W(6)) bus  ();
  cgra_config_streamer_if #(.ADDR_W(4), .CFG_W(6)) bus0 ();

  cgra_config_streamer #(.NUM_PE(16), .ADDR_W(4), .CFG_W(6), .SKIP_ZERO(1'b1)) dut (
    .clk(clk), .reset(reset), .cfg_clear(cfg_clear), .start(start),
    .busy(busy), .done(done), .word_count(word_count), .bus(bus)
  );

  cgra_config_streamer #(.NUM_PE(16), .ADDR_W(4), .CFG_W(6), .SKIP_ZERO(1'b0)) dut_all (
    .clk(clk), .reset(reset), .cfg_clear(cfg_clear0), .start(start0),
    .busy(busy0), .done(done0), .word_count(word_count0), .bus(bus0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] pe;
    logic [5:0] cfg;
    logic [9:0] exp_data;
    logic       exp_par;
  } vec_t;

  vec_t       vecs [5];
  logic [5:0] ref_table [16];
  logic [9:0] got_d [$];
  logic       got_p [$];
  int         errors = 0;
  int         checks = 0;
  int         done_cnt, done_edge, stable_err, busy_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [5:0] d);
    bus.cfg_wr_valid = 1'b1;
    bus.cfg_wr_addr  = a;
    bus.cfg_wr_data  = d;
    ref_table[a]     = d;
    @(negedge clk);
    bus.cfg_wr_valid = 1'b0;
  endtask

  task automatic clr();
    cfg_clear = 1'b1;
    for (int i = 0; i < 16; i++) ref_table[i] = '0;
    @(negedge clk);
    cfg_clear = 1'b0;
  endtask

  // mode 0: always ready, 1: random ready, 2: stall first word 5 cycles,
  // 3: always ready while hammering write/start/clear during the stream
  task automatic stream(input int mode, input bit wr_at_start,
                        input logic [3:0] wa, input logic [5:0] wd);
    int         cyc;
    int         stall;
    bit         r;
    bit         junk;
    bit         prev_hold;
    logic [9:0] prev_d;
    got_d.delete();
    got_p.delete();
    done_cnt = 0; done_edge = -1; stable_err = 0; busy_err = 0;
    if (wr_at_start) begin
      bus.cfg_wr_valid = 1'b1;
      bus.cfg_wr_addr  = wa;
      bus.cfg_wr_data  = wd;
      ref_table[wa]    = wd;
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bus.cfg_wr_valid = 1'b0;
    cyc = 0; stall = 0; prev_hold = 1'b0; prev_d = '0;
    while (cyc < 400) begin
      if (done) begin
        done_cnt++;
        if (done_edge < 0) done_edge = cyc;
      end else if (done_cnt > 0) begin
        break;
      end
      if (!busy || bus.cfg_wr_ready) busy_err++;
      if (prev_hold && (!bus.out_valid || bus.out_data !== prev_d)) stable_err++;
      r = 1'b1;
      if (mode == 1) r = 1'($urandom_range(0, 1));
      if (mode == 2 && bus.out_valid && got_d.size() == 0 && stall < 5) begin
        r = 1'b0;
        stall++;
      end
      if (mode == 3) begin
        junk = (done_cnt == 0);
        bus.cfg_wr_valid = junk;
        bus.cfg_wr_addr  = 4'd5;
        bus.cfg_wr_data  = 6'h3F;
        start            = junk;
        cfg_clear        = junk;
      end
      bus.out_ready = r;
      if (bus.out_valid && r) begin
        got_d.push_back(bus.out_data);
        got_p.push_back(bus.out_parity);
      end
      prev_hold = bus.out_valid && !r;
      prev_d    = bus.out_data;
      @(negedge clk);
      cyc++;
    end
    bus.out_ready = 1'b0; start = 1'b0; cfg_clear = 1'b0; bus.cfg_wr_valid = 1'b0;
    check("stream_timeout", 32'(cyc >= 400), 0);
    check("idle_busy", busy, 0);
    check("idle_wr_ready", bus.cfg_wr_ready, 1);
    check("bp_stable", stable_err, 0);
    check("busy_flags", busy_err, 0);
  endtask

  // Expected stream: every non-zero table entry in address order, parity = XOR of the word.
  task automatic compare_stream(input string tag, input bit timed);
    logic [9:0] exp_d [$];
    int         n;
    for (int a = 0; a < 16; a++)
      if (ref_table[a] != 0) exp_d.push_back({4'(a), ref_table[a]});
    check($sformatf("%s words", tag), got_d.size(), exp_d.size());
    n = (got_d.size() < exp_d.size()) ? got_d.size() : exp_d.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s data[%0d]", tag, i), got_d[i], exp_d[i]);
      check($sformatf("%s parity[%0d]", tag, i), got_p[i], ^exp_d[i]);
    end
    check($sformatf("%s word_count", tag), word_count, exp_d.size());
    check($sformatf("%s done_pulses", tag), done_cnt, 1);
    if (timed) check($sformatf("%s done_cycle", tag), done_edge, 16 + exp_d.size());
  endtask

  initial begin
    int cyc;
    int n;
    int addr_err;
    int nw;
    bit md;
    vecs[0] = '{4'd0,  6'h01, 10'h001, 1'b1};
    vecs[1] = '{4'd3,  6'h0A, 10'h0CA, 1'b0};
    vecs[2] = '{4'd7,  6'h3F, 10'h1FF, 1'b1};
    vecs[3] = '{4'd12, 6'h25, 10'h325, 1'b1};
    vecs[4] = '{4'd15, 6'h30, 10'h3F0, 1'b0};
    for (int i = 0; i < 16; i++) ref_table[i] = '0;

    reset = 1'b0; cfg_clear = 1'b0; start = 1'b0;
    start0 = 1'b0; cfg_clear0 = 1'b0;
    bus.cfg_wr_valid = 1'b0; bus.cfg_wr_addr = '0; bus.cfg_wr_data = '0; bus.out_ready = 1'b0;
    bus0.cfg_wr_valid = 1'b0; bus0.cfg_wr_addr = '0; bus0.cfg_wr_data = '0; bus0.out_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst out_valid", bus.out_valid, 0);
    reset = 1'b1;
    @(negedge clk);
    check("rst wr_ready", bus.cfg_wr_ready, 1);
    check("rst busy", busy, 0);
    check("rst out_valid_after", bus.out_valid, 0);
    check("rst word_count", word_count, 0);
    check("rst out_data", bus.out_data, 0);
    check("rst done", done, 0);

    // Two-entry stream against hand vectors
    wr(vecs[1].pe, vecs[1].cfg);
    wr(vecs[3].pe, vecs[3].cfg);
    stream(0, 1'b0, '0, '0);
    check("t2 words", got_d.size(), 2);
    if (got_d.size() == 2) begin
      check("t2 data0", got_d[0], vecs[1].exp_data);
      check("t2 par0", got_p[0], vecs[1].exp_par);
      check("t2 data1", got_d[1], vecs[3].exp_data);
      check("t2 par1", got_p[1], vecs[3].exp_par);
    end
    check("t2 word_count", word_count, 2);
    check("t2 done_pulses", done_cnt, 1);
    check("t2 done_cycle", done_edge, 18);

    // Backpressure on the first word
    stream(2, 1'b0, '0, '0);
    check("t3 words", got_d.size(), 2);
    if (got_d.size() == 2) begin
      check("t3 data0", got_d[0], vecs[1].exp_data);
      check("t3 data1", got_d[1], vecs[3].exp_data);
    end
    check("t3 done_cycle", done_edge, 23);

    // Full vector table
    for (int i = 0; i < 5; i++) wr(vecs[i].pe, vecs[i].cfg);
    stream(0, 1'b0, '0, '0);
    check("vec words", got_d.size(), 5);
    for (int i = 0; i < 5 && i < got_d.size(); i++) begin
      check($sformatf("vec data[%0d]", i), got_d[i], vecs[i].exp_data);
      check($sformatf("vec par[%0d]", i), got_p[i], vecs[i].exp_par);
    end
    check("vec word_count", word_count, 5);

    // Empty table, SKIP_ZERO=1
    clr();
    stream(0, 1'b0, '0, '0);
    compare_stream("empty", 1'b1);
    check("empty done_at_16", done_edge, 16);

    // Empty table, SKIP_ZERO=0: all 16 addresses in order
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    cyc = 0; n = 0; addr_err = 0;
    while (!done0 && cyc < 200) begin
      if (bus0.out_valid) begin
        if (bus0.out_data !== {4'(n), 6'h00}) addr_err++;
        n++;
      end
      @(negedge clk);
      cyc++;
    end
    check("all words", n, 16);
    check("all addr_order", addr_err, 0);
    check("all done_cycle", cyc, 32);
    check("all word_count", word_count0, 16);

    // Write and start in the same cycle: SCAN sees the new word
    stream(0, 1'b1, 4'd9, 6'h11);
    compare_stream("wr_start", 1'b1);
    if (got_d.size() > 0) check("wr_start hand", got_d[0], 10'h251);

    // Inputs while busy are ignored
    wr(4'd5, 6'h12);
    stream(3, 1'b0, '0, '0);
    compare_stream("busy_ign", 1'b1);
    stream(0, 1'b0, '0, '0);
    compare_stream("busy_after", 1'b1);

    // Randomized tables with random backpressure
    for (int r = 0; r < 8; r++) begin
      if ($urandom_range(0, 3) == 0) clr();
      nw = $urandom_range(1, 6);
      for (int k = 0; k < nw; k++)
        wr(4'($urandom_range(0, 15)),
           ($urandom_range(0, 2) == 0) ? 6'h00 : 6'($urandom_range(1, 63)));
      md = 1'(r % 2);
      stream(md ? 1 : 0, 1'b0, '0, '0);
      compare_stream($sformatf("rand%0d", r), !md);
    end

    // Reset during EMIT under backpressure
    clr();
    wr(4'd2, 6'h07);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!bus.out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("t6 reached_emit", bus.out_valid, 1);
    #2 reset = 1'b0;
    #1;
    check("t6 async_valid", bus.out_valid, 0);
    check("t6 async_busy", busy, 0);
    for (int i = 0; i < 16; i++) ref_table[i] = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    stream(0, 1'b0, '0, '0);
    compare_stream("post_reset", 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
